// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, event kinds,
// machine trap cause codes and the mtvec mode encoding.
package trap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_SAVE,
      ST_REDIRECT,
      ST_SLEEP
   } state_e;

   typedef enum logic [1:0] {
      KIND_TRAP = 2'd0,
      KIND_MRET = 2'd1,
      KIND_WFI  = 2'd2
   } kind_e;

   localparam int unsigned CAUSE_ILLEGAL    = 2;
   localparam int unsigned CAUSE_BREAKPOINT = 3;
   localparam int unsigned CAUSE_ECALL_M    = 11;
   localparam int unsigned CAUSE_IRQ_EXT    = 11;

   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_vector_calc.sv
// Trap target computation: mtvec base, plus 4*cause for interrupts when mtvec
// selects vectored mode.
module trap_vector_calc
   import trap_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] cause_i,
   input  logic            irq_i,
   output logic [XLEN-1:0] target_o
);

   localparam logic [XLEN-1:0] CODE_MASK = {1'b0, {(XLEN-1){1'b1}}};

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   always_comb begin
      base     = {mtvec_i[XLEN-1:2], 2'b00};
      offset   = (cause_i & CODE_MASK) << 2;
      target_o = base;
      if (irq_i && (mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
         target_o = base + offset;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences exceptions, interrupts, mret and wfi: stall/flush, trap CSR write,
// mstatus update and PC redirect, plus WFI sleep.
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned IRQ_CAUSE = CAUSE_IRQ_EXT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            insn_valid_i,
   input  logic [XLEN-1:0] insn_pc_i,
   input  logic [31:0]     insn_word_i,
   input  logic            ecall_insn_i,
   input  logic            ebrk_insn_i,
   input  logic            mret_insn_i,
   input  logic            dret_insn_i,
   input  logic            wfi_insn_i,
   input  logic            illegal_insn_i,
   input  logic            irq_pending_i,
   input  logic            mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic            csr_we_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] mtval_o,
   output logic            mstatus_trap_o,
   output logic            mstatus_mret_o,
   output logic            pc_redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            sleeping_o
);

   localparam logic [XLEN-1:0] IRQ_MCAUSE = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(IRQ_CAUSE);

   state_e          state_q, state_d;
   kind_e           kind_q, kind_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] tval_q, tval_d;

   logic            ev_hit;
   kind_e           ev_kind;
   logic [XLEN-1:0] ev_cause;
   logic [XLEN-1:0] ev_tval;
   logic [XLEN-1:0] vec_target;

   // Event priority: interrupt, illegal/dret, ebreak, ecall, mret, wfi.
   always_comb begin
      ev_hit   = 1'b1;
      ev_kind  = KIND_TRAP;
      ev_cause = '0;
      ev_tval  = '0;
      if (irq_pending_i && mie_i) begin
         ev_cause = IRQ_MCAUSE;
      end else if (illegal_insn_i || dret_insn_i) begin
         ev_cause = XLEN'(CAUSE_ILLEGAL);
         ev_tval  = XLEN'(insn_word_i);
      end else if (ebrk_insn_i) begin
         ev_cause = XLEN'(CAUSE_BREAKPOINT);
         ev_tval  = insn_pc_i;
      end else if (ecall_insn_i) begin
         ev_cause = XLEN'(CAUSE_ECALL_M);
      end else if (mret_insn_i) begin
         ev_kind = KIND_MRET;
      end else if (wfi_insn_i) begin
         ev_kind = KIND_WFI;
      end else begin
         ev_hit = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      tval_d  = tval_q;
      case (state_q)
         ST_IDLE: begin
            if (insn_valid_i && ev_hit) begin
               kind_d  = ev_kind;
               pc_d    = insn_pc_i;
               cause_d = ev_cause;
               tval_d  = ev_tval;
               state_d = (ev_kind == KIND_WFI) ? ST_SLEEP : ST_FLUSH;
            end
         end
         ST_FLUSH:    state_d = (kind_q == KIND_MRET) ? ST_REDIRECT : ST_SAVE;
         ST_SAVE:     state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_IDLE;
         ST_SLEEP: begin
            if (irq_pending_i) begin
               state_d = ST_IDLE;
            end
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         kind_q  <= KIND_TRAP;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
      end
   end

   trap_vector_calc #(
      .XLEN (XLEN)
   ) u_vec (
      .mtvec_i  (mtvec_i),
      .cause_i  (cause_q),
      .irq_i    (cause_q[XLEN-1]),
      .target_o (vec_target)
   );

   // Outputs decode only the state register and capture registers, so every
   // pulse is exactly one state, i.e. one cycle.
   always_comb begin
      stall_o        = 1'b0;
      flush_o        = 1'b0;
      csr_we_o       = 1'b0;
      mepc_o         = '0;
      mcause_o       = '0;
      mtval_o        = '0;
      mstatus_trap_o = 1'b0;
      mstatus_mret_o = 1'b0;
      pc_redirect_o  = 1'b0;
      redirect_pc_o  = '0;
      sleeping_o     = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            stall_o = 1'b1;
            flush_o = 1'b1;
         end
         ST_SAVE: begin
            stall_o        = 1'b1;
            csr_we_o       = 1'b1;
            mstatus_trap_o = 1'b1;
            mepc_o         = pc_q;
            mcause_o       = cause_q;
            mtval_o        = tval_q;
         end
         ST_REDIRECT: begin
            stall_o       = 1'b1;
            pc_redirect_o = 1'b1;
            if (kind_q == KIND_MRET) begin
               mstatus_mret_o = 1'b1;
               redirect_pc_o  = mepc_i;
            end else begin
               redirect_pc_o = vec_target;
            end
         end
         ST_SLEEP: begin
            stall_o    = 1'b1;
            sleeping_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed vector table, randomized run against a
// cycle-queue reference model, and hand-written wfi/reset sequences.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        insn_valid;
   logic [31:0] insn_pc, insn_word;
   logic        ecall, ebrk, mret, dret, wfi, illegal, irq, mie;
   logic [31:0] mtvec, mepc;
   logic        stall_o, flush_o, csr_we_o, mstatus_trap_o, mstatus_mret_o;
   logic        pc_redirect_o, sleeping_o;
   logic [31:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;

   always #5 clk = ~clk;

   trap_sequencer #(
      .XLEN      (32),
      .IRQ_CAUSE (11)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .insn_valid_i   (insn_valid),
      .insn_pc_i      (insn_pc),
      .insn_word_i    (insn_word),
      .ecall_insn_i   (ecall),
      .ebrk_insn_i    (ebrk),
      .mret_insn_i    (mret),
      .dret_insn_i    (dret),
      .wfi_insn_i     (wfi),
      .illegal_insn_i (illegal),
      .irq_pending_i  (irq),
      .mie_i          (mie),
      .mtvec_i        (mtvec),
      .mepc_i         (mepc),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .csr_we_o       (csr_we_o),
      .mepc_o         (mepc_o),
      .mcause_o       (mcause_o),
      .mtval_o        (mtval_o),
      .mstatus_trap_o (mstatus_trap_o),
      .mstatus_mret_o (mstatus_mret_o),
      .pc_redirect_o  (pc_redirect_o),
      .redirect_pc_o  (redirect_pc_o),
      .sleeping_o     (sleeping_o)
   );

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic        we;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] mtval;
      logic        trap;
      logic        mret;
      logic        redir;
      logic [31:0] rpc;
      logic        sleep;
   } outs_t;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] word;
      logic [5:0]  flags;   // {illegal, dret, ebrk, ecall, mret, wfi}
      logic        irq;
      logic        mie;
      logic [31:0] mtvec;
      logic [31:0] mepc;
   } in_t;

   localparam logic [5:0] F_ILL = 6'b100000, F_DRET = 6'b010000, F_EBRK = 6'b001000;
   localparam logic [5:0] F_ECALL = 6'b000100, F_MRET = 6'b000010, F_WFI = 6'b000001;
   localparam int K_TRAP = 0, K_MRET = 1, K_NONE = 2;

   typedef struct {
      in_t         in;
      int          kind;
      logic [31:0] cause;
      logic [31:0] tval;
      logic [31:0] rpc;
   } vec_t;

   typedef struct {
      outs_t o;
      int    rsel;   // 0: no redirect, 1: trap vector, 2: mepc_i
      logic  virq;
   } mstep_t;

   int     total = 0;
   int     bad = 0;
   int     sleep_seen = 0;
   int     redir_seen = 0;
   vec_t   tbl[$];
   mstep_t mq[$];
   bit     m_sleep = 0;

   function automatic in_t mkin(logic v, logic [31:0] pc, logic [31:0] w, logic [5:0] f,
                                logic i, logic m, logic [31:0] tv, logic [31:0] ep);
      in_t r;
      r.valid = v; r.pc = pc; r.word = w; r.flags = f;
      r.irq = i; r.mie = m; r.mtvec = tv; r.mepc = ep;
      return r;
   endfunction

   function automatic in_t idle_in(logic i);
      return mkin(1'b0, 32'h0, 32'h0, 6'b0, i, 1'b0, 32'h200, 32'h0);
   endfunction

   task automatic drive(in_t i);
      insn_valid = i.valid; insn_pc = i.pc; insn_word = i.word;
      {illegal, dret, ebrk, ecall, mret, wfi} = i.flags;
      irq = i.irq; mie = i.mie; mtvec = i.mtvec; mepc = i.mepc;
   endtask

   function automatic outs_t dut_outs();
      outs_t o;
      o.stall = stall_o; o.flush = flush_o; o.we = csr_we_o;
      o.mepc = mepc_o; o.mcause = mcause_o; o.mtval = mtval_o;
      o.trap = mstatus_trap_o; o.mret = mstatus_mret_o; o.redir = pc_redirect_o;
      o.rpc = redirect_pc_o; o.sleep = sleeping_o;
      return o;
   endfunction

   function automatic string fmt(outs_t o);
      return $sformatf("stall=%0b flush=%0b we=%0b mepc=%h mcause=%h mtval=%h trap=%0b mret=%0b redir=%0b rpc=%h sleep=%0b",
                       o.stall, o.flush, o.we, o.mepc, o.mcause, o.mtval, o.trap, o.mret, o.redir, o.rpc, o.sleep);
   endfunction

   task automatic check(string tag, outs_t e);
      outs_t a;
      a = dut_outs();
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got {%s} want {%s}", tag, fmt(a), fmt(e));
      end
   endtask

   task automatic check_val(string tag, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, a, e);
      end
   endtask

   function automatic logic [31:0] vec_of(logic [31:0] tv, logic is_irq);
      logic [31:0] b;
      b = tv & 32'hFFFF_FFFC;
      if (is_irq && tv[1:0] == 2'b01) return b + 32'd4 * 32'd11;
      return b;
   endfunction

   // Reference model: an accepted event appends the cycles it will occupy.
   task automatic model_event(in_t i);
      mstep_t s;
      logic [31:0] cause, tval;
      logic is_trap, virq;
      is_trap = 0; virq = 0; cause = 0; tval = 0;
      s.o = '0; s.rsel = 0; s.virq = 0;
      if (!i.valid) return;
      if (i.irq && i.mie) begin is_trap = 1; cause = 32'h8000_000B; virq = 1; end
      else if (i.flags[5] || i.flags[4]) begin is_trap = 1; cause = 2; tval = i.word; end
      else if (i.flags[3]) begin is_trap = 1; cause = 3; tval = i.pc; end
      else if (i.flags[2]) begin is_trap = 1; cause = 11; end
      else if (i.flags[1]) begin
         s.o.stall = 1; s.o.flush = 1; mq.push_back(s);
         s.o = '0; s.o.stall = 1; s.o.redir = 1; s.o.mret = 1; s.rsel = 2; mq.push_back(s);
      end
      else if (i.flags[0]) m_sleep = 1;
      if (is_trap) begin
         s.o.stall = 1; s.o.flush = 1; mq.push_back(s);
         s.o = '0; s.o.stall = 1; s.o.we = 1; s.o.trap = 1;
         s.o.mepc = i.pc; s.o.mcause = cause; s.o.mtval = tval; mq.push_back(s);
         s.o = '0; s.o.stall = 1; s.o.redir = 1; s.rsel = 1; s.virq = virq; mq.push_back(s);
      end
   endtask

   task automatic step(string tag, in_t i);
      outs_t e;
      bit busy, was_sleep;
      mstep_t s;
      @(negedge clk);
      e = '0; busy = 0; was_sleep = m_sleep;
      if (m_sleep) begin
         e.stall = 1; e.sleep = 1; busy = 1;
      end else if (mq.size() > 0) begin
         s = mq.pop_front();
         e = s.o; busy = 1;
         if (s.rsel == 1) e.rpc = vec_of(mtvec, s.virq);
         if (s.rsel == 2) e.rpc = mepc;
      end
      check(tag, e);
      if (sleeping_o) sleep_seen++;
      if (pc_redirect_o) redir_seen++;
      drive(i);
      if (was_sleep) begin
         if (i.irq) m_sleep = 0;
      end else if (!busy && !rst) begin
         model_event(i);
      end
   endtask

   task automatic add(in_t i, int k, logic [31:0] c, logic [31:0] t, logic [31:0] r);
      vec_t v;
      v.in = i; v.kind = k; v.cause = c; v.tval = t; v.rpc = r;
      tbl.push_back(v);
   endtask

   initial begin
      outs_t e;
      in_t   r;
      drive(idle_in(1'b0));

      #12;
      check("reset_state", '0);
      @(negedge clk);
      rst = 1'b0;

      add(mkin(1, 32'h100, 32'hFFFF_FFFF, F_ILL,   0, 0, 32'h200, 0), K_TRAP, 32'h2, 32'hFFFF_FFFF, 32'h200);
      add(mkin(1, 32'h40,  32'h0000_0073, F_ECALL, 1, 0, 32'h200, 0), K_TRAP, 32'hB, 32'h0, 32'h200);
      add(mkin(1, 32'h40,  32'h0000_0073, F_ECALL, 1, 1, 32'h301, 0), K_TRAP, 32'h8000_000B, 32'h0, 32'h32C);
      add(mkin(1, 32'h500, 32'h3020_0073, F_MRET,  0, 0, 32'h200, 32'h1234), K_MRET, 0, 0, 32'h1234);
      add(mkin(1, 32'h80,  32'h7B20_0073, F_DRET,  0, 0, 32'h200, 0), K_TRAP, 32'h2, 32'h7B20_0073, 32'h200);
      add(mkin(1, 32'h88,  32'h0010_0073, F_EBRK,  0, 1, 32'h301, 0), K_TRAP, 32'h3, 32'h88, 32'h300);
      add(mkin(1, 32'hC0,  32'hDEAD_BEEF, 6'b111111, 0, 1, 32'h400, 0), K_TRAP, 32'h2, 32'hDEAD_BEEF, 32'h400);
      add(mkin(1, 32'hC4,  32'h1, F_EBRK | F_ECALL | F_MRET, 0, 0, 32'h400, 0), K_TRAP, 32'h3, 32'hC4, 32'h400);
      add(mkin(1, 32'hC8,  32'h2, F_MRET | F_WFI, 1, 0, 32'h400, 32'h5550), K_MRET, 0, 0, 32'h5550);
      add(mkin(1, 32'hCC,  32'h3, 6'b0, 1, 1, 32'h1001, 0), K_TRAP, 32'h8000_000B, 32'h0, 32'h102C);
      add(mkin(0, 32'hD0,  32'h4, F_ECALL, 1, 1, 32'h200, 0), K_NONE, 0, 0, 0);
      add(mkin(1, 32'hD4,  32'h5, 6'b0, 1, 0, 32'h200, 0), K_NONE, 0, 0, 0);

      foreach (tbl[n]) begin
         @(negedge clk);
         check($sformatf("tbl%0d_idle", n), '0);
         drive(tbl[n].in);
         r = mkin(0, 0, 0, 6'b0, 0, 0, tbl[n].in.mtvec, tbl[n].in.mepc);
         @(negedge clk);
         e = '0;
         if (tbl[n].kind != K_NONE) begin e.stall = 1; e.flush = 1; end
         check($sformatf("tbl%0d_flush", n), e);
         drive(r);
         @(negedge clk);
         e = '0;
         if (tbl[n].kind == K_TRAP) begin
            e.stall = 1; e.we = 1; e.trap = 1;
            e.mepc = tbl[n].in.pc; e.mcause = tbl[n].cause; e.mtval = tbl[n].tval;
         end else if (tbl[n].kind == K_MRET) begin
            e.stall = 1; e.redir = 1; e.mret = 1; e.rpc = tbl[n].rpc;
         end
         check($sformatf("tbl%0d_t2", n), e);
         @(negedge clk);
         e = '0;
         if (tbl[n].kind == K_TRAP) begin
            e.stall = 1; e.redir = 1; e.rpc = tbl[n].rpc;
         end
         check($sformatf("tbl%0d_t3", n), e);
      end

      for (int k = 0; k < 3000; k++) begin
         r.valid = ($urandom_range(0, 3) != 0);
         r.pc    = $urandom & 32'hFFFF_FFFC;
         r.word  = $urandom;
         for (int b = 0; b < 6; b++) r.flags[b] = ($urandom_range(0, 9) == 0);
         r.irq   = ($urandom_range(0, 3) == 0);
         r.mie   = $urandom_range(0, 1);
         r.mtvec = $urandom;
         r.mepc  = $urandom;
         step("rand", r);
      end
      for (int k = 0; k < 6; k++) step("drain", idle_in(1'b0));

      sleep_seen = 0; redir_seen = 0;
      step("wfi_issue", mkin(1, 32'h600, 32'h1050_0073, F_WFI, 0, 1, 32'h200, 0));
      for (int k = 0; k < 9; k++) step("wfi_sleep", mkin(1, 32'h604, 32'h73, F_ECALL, 0, 1, 32'h200, 0));
      step("wfi_sleep", idle_in(1'b1));
      step("wfi_wake", idle_in(1'b0));
      check_val("wfi_sleep_cycles", sleep_seen, 10);
      check_val("wfi_no_redirect", redir_seen, 0);

      step("wfi_irq_hi", mkin(1, 32'h700, 32'h1050_0073, F_WFI, 1, 0, 32'h200, 0));
      step("wfi_one", idle_in(1'b1));
      step("wfi_one_wake", mkin(1, 32'h704, 32'h13, 6'b0, 1, 1, 32'h301, 0));
      for (int k = 0; k < 4; k++) step("irq_after_wfi", idle_in(1'b0));

      step("rst_issue", mkin(1, 32'h800, 32'h0, F_ILL, 0, 0, 32'h200, 0));
      step("rst_flush", idle_in(1'b0));
      step("rst_save", idle_in(1'b0));
      #2 rst = 1'b1;
      #1 check("rst_async_clear", '0);
      mq.delete(); m_sleep = 0;
      step("rst_hold", idle_in(1'b0));
      step("rst_hold", idle_in(1'b0));
      rst = 1'b0;
      redir_seen = 0;
      for (int k = 0; k < 4; k++) step("rst_after", idle_in(1'b0));
      check_val("rst_no_redirect", redir_seen, 0);
      step("ebrk_issue", mkin(1, 32'h300, 32'h0010_0073, F_EBRK, 0, 0, 32'h200, 0));
      step("ebrk_flush", idle_in(1'b0));
      step("ebrk_save", idle_in(1'b0));
      check_val("ebrk_mcause", mcause_o, 32'h3);
      check_val("ebrk_mtval", mtval_o, 32'h300);
      for (int k = 0; k < 3; k++) step("ebrk_tail", idle_in(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences the core's response to the decoder's system/exception flags: ecall, ebreak, mret, dret, wfi, illegal, plus one external interrupt.
- Sits between instruction decode and the fetch/CSR logic.
- Stalls and flushes the pipeline, writes the trap CSRs (mepc/mcause/mtval), toggles mstatus, and redirects the PC to the trap vector or to mepc.
- Parks the core in a sleep state for WFI.

Parameters:
- XLEN, 32, data/address width.
- IRQ_CAUSE, 11, interrupt cause code (machine external); the interrupt bit is set in mcause[XLEN-1].

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- insn_valid_i  in  1  decode stage holds a valid instruction this cycle
- insn_pc_i  in  XLEN  PC of the decoded instruction
- insn_word_i  in  32  raw instruction word
- ecall_insn_i, ebrk_insn_i, mret_insn_i, dret_insn_i, wfi_insn_i, illegal_insn_i  in  1 each  decoder flags
- irq_pending_i  in  1  level external interrupt request
- mie_i  in  1  mstatus.MIE
- mtvec_i  in  XLEN  trap vector CSR
- mepc_i  in  XLEN  current mepc CSR (return target)
- stall_o  out  1  hold fetch/decode
- flush_o  out  1  kill in-flight younger instructions
- csr_we_o  out  1  write mepc/mcause/mtval this cycle
- mepc_o, mcause_o, mtval_o  out  XLEN each  trap CSR write data
- mstatus_trap_o  out  1  pulse: MPIE<=MIE, MIE<=0
- mstatus_mret_o  out  1  pulse: MIE<=MPIE, MPIE<=1
- pc_redirect_o  out  1  pulse: fetch loads redirect_pc_o
- redirect_pc_o  out  XLEN  redirect target
- sleeping_o  out  1  core in WFI sleep

Behaviour:
- States: IDLE, FLUSH, SAVE, REDIRECT, SLEEP. Reset (async, rst=1): state IDLE, all outputs 0, internal captured pc/cause/tval/kind registers 0. Reset mid-sequence aborts it with no further CSR writes or redirects.
- Event detection in IDLE when insn_valid_i=1, priority high to low:
  - interrupt (irq_pending_i & mie_i)
  - illegal (illegal_insn_i | dret_insn_i; there is no debug mode, so dret is illegal)
  - ebreak
  - ecall
  - mret
  - wfi
- No event: remain IDLE, all outputs 0.
- Capture on event:
  - pc = insn_pc_i.
  - cause: interrupt = {1'b1, IRQ_CAUSE}; illegal = 2; ebreak = 3; ecall = 11.
  - tval: illegal = insn_word_i; ebreak = insn_pc_i; otherwise 0.
- Trap path (interrupt/illegal/ebreak/ecall):
  - IDLE -> FLUSH: stall_o=1, flush_o=1.
  - FLUSH -> SAVE: stall_o=1, csr_we_o=1, mstatus_trap_o=1, mepc_o=pc, mcause_o=cause, mtval_o=tval.
  - SAVE -> REDIRECT: stall_o=1, pc_redirect_o=1, redirect_pc_o = {mtvec_i[XLEN-1:2],2'b00}. When mtvec_i[1:0]==01 and the event is an interrupt, add 4*IRQ_CAUSE instead.
  - REDIRECT -> IDLE.
  - The trapping instruction does not retire; mepc = its own PC (for an interrupt, the PC of the not-yet-executed instruction).
  - Redirect occurs 3 cycles after detection.
- mret path:
  - IDLE -> FLUSH (stall, flush) -> REDIRECT: pc_redirect_o=1, redirect_pc_o=mepc_i sampled in that cycle, mstatus_mret_o=1.
  - REDIRECT -> IDLE. csr_we_o stays 0.
- wfi path:
  - IDLE -> SLEEP: stall_o=1, sleeping_o=1, no flush.
  - Wake on irq_pending_i=1, regardless of mie_i: SLEEP -> IDLE the next cycle. The WFI then retires normally (fetch continues at pc+4).
  - If mie_i=1 the interrupt is taken on the next valid instruction.
  - irq_pending_i already high when WFI is detected: enter SLEEP for exactly one cycle.
- Decoder flags and irq_pending_i are ignored outside IDLE.
- insn_valid_i=0 in IDLE: no event, even if irq is pending.
- Outputs are registered state decodes; all pulses last exactly one cycle.
- Multiple decoder flags asserted together resolve by the priority above.

Decomposition:
- Shared package trap_pkg holds:
  - state enum
  - cause constants CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11, CAUSE_IRQ_EXT=11
  - event-kind encoding (TRAP, MRET, WFI)
  - MTVEC_MODE_VECTORED=2'b01
- One sub-module is natural: trap_vector_calc, combinational target computation from mtvec, cause and irq flag.
- FSM and capture registers stay in trap_sequencer.

Test Plan:
- Illegal instruction: insn_word 0xFFFFFFFF, pc 0x100, mtvec 0x200 -> flush at T+1; SAVE at T+2 with mepc 0x100, mcause 2, mtval 0xFFFFFFFF; redirect to 0x200 at T+3.
- ecall at pc 0x40 while irq_pending_i=1, mie_i=0 -> mcause 11, mtval 0. Repeat with mie_i=1 and mtvec 0x301 -> mcause 0x8000000B, redirect 0x32C.
- mret with mepc_i 0x1234 -> redirect to 0x1234 at T+2, mstatus_mret_o pulse, csr_we_o never asserted.
- wfi with irq low for 10 cycles -> stall_o and sleeping_o high for 10 cycles; irq rises -> IDLE the next cycle, no redirect.
- dret at pc 0x80 -> identical to illegal: mcause 2, mtval = insn word.
- rst asserted in SAVE -> all outputs 0 immediately; no redirect after release; next ebreak behaves normally (mcause 3, mtval = pc).
